// File: rtl/pdm_dac_tx.sv
// rtl/pdm_dac_tx.sv - PCM-to-PDM transmitter: sample FIFO, PDM clock divider,
// per-sample hold counter and first-order carry-out sigma-delta modulator.
module pdm_dac_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int LOW_THRESH = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [7:0]                    period,
  input  logic [7:0]                    osr,
  input  logic [15:0]                   pcm_in,
  input  logic                          pcm_valid,
  output logic                          pcm_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          pdm_clk,
  output logic                          pdm_dat,
  output logic                          underrun,
  input  logic                          underrun_clr,
  output logic                          irq_low
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];
  localparam logic [AW:0] LOW_L   = LOW_THRESH[AW:0];

  logic [7:0]    phase_q, phase_d;
  logic [7:0]    hold_q, hold_d;
  logic [15:0]   acc_q, acc_d;
  logic [15:0]   cur_q, cur_d;
  logic          pdm_clk_q, pdm_clk_d;
  logic          pdm_dat_q, pdm_dat_d;
  logic          underrun_q, underrun_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   level_q, level_d;

  logic [7:0]    half;
  logic [7:0]    osr_last;
  logic          running, tick, fifo_empty, pop_slot, pop, push;
  logic [15:0]   s;
  logic [16:0]   sum;

  assign half       = {1'b0, period[7:1]};
  // osr==0 wraps to 255 here, giving the 256-bit hold for free.
  assign osr_last   = osr - 8'd1;
  assign running    = enable & (period >= 8'd2);
  assign tick       = running & (phase_q == half);
  assign fifo_empty = (level_q == '0);
  assign pop_slot   = tick & (hold_q == 8'd0);
  assign pop        = pop_slot & ~fifo_empty;
  assign push       = pcm_valid & pcm_ready;
  assign s          = pop ? mem_q[rd_q] : cur_q;
  assign sum        = {1'b0, acc_q} + {1'b0, ~s[15], s[14:0]};

  always_comb begin
    phase_d    = phase_q;
    hold_d     = hold_q;
    acc_d      = acc_q;
    cur_d      = cur_q;
    pdm_dat_d  = pdm_dat_q;
    pdm_clk_d  = running & (phase_q < half);
    underrun_d = underrun_q;
    mem_d      = mem_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    level_d    = level_q;

    if (!running) begin
      phase_d   = 8'd0;
      hold_d    = 8'd0;
      acc_d     = 16'd0;
      pdm_dat_d = 1'b0;
    end else begin
      // >= rather than == so a shrunk period/osr wraps instead of running away.
      phase_d = (phase_q >= period - 8'd1) ? 8'd0 : phase_q + 8'd1;
      if (tick) begin
        hold_d    = (hold_q >= osr_last) ? 8'd0 : hold_q + 8'd1;
        acc_d     = sum[15:0];
        pdm_dat_d = sum[16];
      end
    end

    if (pop)
      cur_d = mem_q[rd_q];

    if (pop_slot && fifo_empty)
      underrun_d = 1'b1;
    else if (underrun_clr)
      underrun_d = 1'b0;

    if (push) begin
      mem_d[wr_q] = pcm_in;
      wr_d        = wr_q + 1'b1;
    end
    if (pop)
      rd_d = rd_q + 1'b1;
    if (push && !pop)
      level_d = level_q + 1'b1;
    else if (pop && !push)
      level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= 8'd0;
      hold_q     <= 8'd0;
      acc_q      <= 16'd0;
      cur_q      <= 16'd0;
      pdm_clk_q  <= 1'b0;
      pdm_dat_q  <= 1'b0;
      underrun_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= 16'd0;
    end else begin
      phase_q    <= phase_d;
      hold_q     <= hold_d;
      acc_q      <= acc_d;
      cur_q      <= cur_d;
      pdm_clk_q  <= pdm_clk_d;
      pdm_dat_q  <= pdm_dat_d;
      underrun_q <= underrun_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      level_q    <= level_d;
      mem_q      <= mem_d;
    end
  end

  assign pcm_ready  = (level_q < DEPTH_L);
  assign fifo_level = level_q;
  assign pdm_clk    = pdm_clk_q;
  assign pdm_dat    = pdm_dat_q;
  assign underrun   = underrun_q;
  assign irq_low    = enable & (level_q <= LOW_L);

endmodule

// File: tb/tb_pdm_dac_tx.sv
// tb/tb_pdm_dac_tx.sv - scoreboard bench for pdm_dac_tx: expected PDM bits
// queued per pushed sample, compared on each observed pdm_clk rise.
module tb_pdm_dac_tx;

  logic        clk = 1'b0;
  logic        rst, enable, pcm_valid, underrun_clr;
  logic [7:0]  period, osr;
  logic [15:0] pcm_in;
  logic        pcm_ready, pdm_clk, pdm_dat, underrun, irq_low;
  logic [2:0]  fifo_level;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_q[$];
  logic [15:0] m_acc;

  always #5 clk = ~clk;

  pdm_dac_tx #(.FIFO_DEPTH(4), .LOW_THRESH(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .osr(osr),
    .pcm_in(pcm_in), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready),
    .fifo_level(fifo_level), .pdm_clk(pdm_clk), .pdm_dat(pdm_dat),
    .underrun(underrun), .underrun_clr(underrun_clr), .irq_low(irq_low)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    @(negedge clk);
    pcm_in    = v;
    pcm_valid = 1'b1;
    @(negedge clk);
    pcm_valid = 1'b0;
  endtask

  // Reference first-order modulator: queue n output bits for sample s.
  task automatic model_sample(input logic [15:0] s, input int n);
    logic [16:0] sm;
    for (int i = 0; i < n; i++) begin
      sm    = {1'b0, m_acc} + {1'b0, ~s[15], s[14:0]};
      m_acc = sm[15:0];
      exp_q.push_back(sm[16]);
    end
  endtask

  task automatic run_rises(input int n, input int exp_period);
    int   got = 0;
    int   cyc = 0;
    int   since = 0;
    logic prev;
    prev = pdm_clk;
    while (got < n && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      since++;
      if (pdm_clk && !prev) begin
        if (exp_q.size() == 0)
          check("sb_empty", 1, 0);
        else
          check("pdm_dat", pdm_dat, exp_q.pop_front());
        if (got == 1)
          check("clk_period", since, exp_period);
        got++;
        since = 0;
      end
      prev = pdm_clk;
    end
    if (got < n)
      check("rise_timeout", got, n);
  endtask

  initial begin
    int hi;
    int seen;
    int cyc;

    rst = 1'b1; enable = 1'b0; period = 8'd4; osr = 8'd8;
    pcm_in = 16'd0; pcm_valid = 1'b0; underrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", pcm_ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_pdm_clk", pdm_clk, 0);
    check("rst_pdm_dat", pdm_dat, 0);
    check("rst_underrun", underrun, 0);
    check("rst_irq", irq_low, 0);

    // Prefill while idle, including one push attempt against a full FIFO.
    push(16'h0000); push(16'h4000); push(16'h8000); push(16'h1234);
    check("full_level", fifo_level, 4);
    check("full_ready", pcm_ready, 0);
    push(16'h7FFF);
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (pdm_clk) hi++;
    end
    check("idle_no_clk", hi, 0);
    check("idle_level", fifo_level, 4);

    m_acc = 16'd0;
    exp_q.push_back(1'b0);
    model_sample(16'h0000, 8);
    model_sample(16'h4000, 8);
    model_sample(16'h8000, 8);
    model_sample(16'h1234, 16);
    enable = 1'b1;
    run_rises(41, 4);
    check("ur_set", underrun, 1);
    check("ur_level", fifo_level, 0);
    check("ur_irq", irq_low, 1);

    repeat (4) @(negedge clk);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("ur_clr", underrun, 0);
    seen = 0;
    underrun_clr = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (underrun) seen = 1;
    end
    underrun_clr = 1'b0;
    check("ur_set_over_clr", seen, 1);

    // Reset while streaming.
    push(16'h1111);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ready", pcm_ready, 1);
    check("mid_rst_clk", pdm_clk, 0);
    check("mid_rst_dat", pdm_dat, 0);
    check("mid_rst_ur", underrun, 0);
    enable = 1'b0;

    push(16'hABCD);
    for (int p = 0; p < 2; p++) begin
      period = (p == 0) ? 8'd1 : 8'd0;
      enable = 1'b1;
      hi = 0;
      repeat (30) begin
        @(negedge clk);
        if (pdm_clk) hi++;
      end
      check("short_period_clk", hi, 0);
      check("short_period_level", fifo_level, 1);
    end
    enable = 1'b0;

    // osr=0 holds each sample for 256 ticks; period=2 ticks every 2 cycles.
    push(16'h0100);
    period = 8'd2;
    osr    = 8'd0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("osr0_irq_lvl2", irq_low, 0);
    cyc = 0;
    while (fifo_level != 3'd1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("osr0_first_pop", fifo_level, 1);
    check("osr0_irq_lvl1", irq_low, 1);
    cyc = 0;
    while (fifo_level != 3'd0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("osr0_pop_spacing", cyc, 512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
